alu_check: RTL

Self-checking result monitor for the 8-bit ALU: samples each presented operand/select/result/carry vector, recomputes the expected result with an internal golden model, and keeps running pass/error/skip statistics plus a snapshot of the first failure. It sits on the ALU output side, the consumer end of the A/B/ALU_Sel → ALU_Out/CarryOut interface. It lets the stimulus sweep run as a pass/fail hardware test, on an FPGA or in simulation, without waveform inspection.

---
 rtl/alu_check_if.sv | 18 +
 rtl/alu_check.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_check_if.sv
// Vector bus between the ALU stimulus/observation side and the result monitor.
// One vector = operands, select, observed result and carry, qualified by in_valid.
interface alu_check_if;
   logic       in_valid;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic [3:0] in_sel;
   logic [7:0] in_out;
   logic       in_carry;

   modport master (
      output in_valid, in_a, in_b, in_sel, in_out, in_carry
   );

   modport slave (
      input in_valid, in_a, in_b, in_sel, in_out, in_carry
   );
endinterface

// File: rtl/alu_check.sv
// Self-checking ALU result monitor: recomputes each presented vector with a
// golden model and keeps saturating pass/error/skip statistics plus a first-failure snapshot.
module alu_check #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             start,
   input  logic [CNT_W-1:0] expect_n,
   alu_check_if.slave       vec,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             mismatch,
   output logic [CNT_W-1:0] chk_count,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] skip_count,
   output logic             first_valid,
   output logic [3:0]       first_sel,
   output logic [7:0]       first_a,
   output logic [7:0]       first_b,
   output logic [7:0]       first_got,
   output logic [7:0]       first_exp,
   output logic             first_cgot,
   output logic             first_cexp
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t           state_q;
   state_t           state_d;

   logic             s1_valid;
   logic [7:0]       s1_a;
   logic [7:0]       s1_b;
   logic [3:0]       s1_sel;
   logic [7:0]       s1_out;
   logic             s1_carry;

   logic [CNT_W-1:0] expect_q;
   logic [CNT_W-1:0] acc_q;

   logic [8:0]       sum9;
   logic [7:0]       gold;
   logic             gold_c;
   logic             fire;
   logic             is_skip;
   logic             is_fail;
   logic             last;
   logic             start_run;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + ONE;
   endfunction

   // Golden model evaluated on the stage-1 vector; carry is always the add carry.
   always_comb begin
      sum9   = {1'b0, s1_a} + {1'b0, s1_b};
      gold_c = sum9[8];
      gold   = 8'h00;
      case (s1_sel)
         4'd0:  gold = sum9[7:0];
         4'd1:  gold = s1_a - s1_b;
         4'd2:  gold = s1_a * s1_b;
         4'd3:  gold = (s1_b == 8'h00) ? 8'h00 : s1_a / s1_b;
         4'd4:  gold = {s1_a[6:0], 1'b0};
         4'd5:  gold = {1'b0, s1_a[7:1]};
         4'd6:  gold = {s1_a[6:0], s1_a[7]};
         4'd7:  gold = {s1_a[0], s1_a[7:1]};
         4'd8:  gold = s1_a & s1_b;
         4'd9:  gold = s1_a | s1_b;
         4'd10: gold = s1_a ^ s1_b;
         4'd11: gold = ~(s1_a | s1_b);
         4'd12: gold = ~(s1_a & s1_b);
         4'd13: gold = ~(s1_a ^ s1_b);
         4'd14: gold = {7'd0, (s1_a > s1_b)};
         4'd15: gold = {7'd0, (s1_a == s1_b)};
         default: gold = 8'h00;
      endcase
   end

   always_comb begin
      fire      = s1_valid && (state_q == RUN);
      is_skip   = (s1_sel == 4'd3) && (s1_b == 8'h00);
      is_fail   = fire && !is_skip && ((s1_out != gold) || (s1_carry != gold_c));
      last      = fire && (expect_q != '0) && ((acc_q + ONE) == expect_q);
      start_run = start && ((state_q == IDLE) || (state_q == DONE));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Clear wins over start; a run ends on the edge that accepts the final vector.
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid    <= 1'b0;
         s1_a        <= 8'h00;
         s1_b        <= 8'h00;
         s1_sel      <= 4'h0;
         s1_out      <= 8'h00;
         s1_carry    <= 1'b0;
         expect_q    <= '0;
         acc_q       <= '0;
         mismatch    <= 1'b0;
         chk_count   <= '0;
         err_count   <= '0;
         skip_count  <= '0;
         first_valid <= 1'b0;
         first_sel   <= 4'h0;
         first_a     <= 8'h00;
         first_b     <= 8'h00;
         first_got   <= 8'h00;
         first_exp   <= 8'h00;
         first_cgot  <= 1'b0;
         first_cexp  <= 1'b0;
      end else if (clear || start_run) begin
         s1_valid    <= 1'b0;
         expect_q    <= clear ? '0 : expect_n;
         acc_q       <= '0;
         mismatch    <= 1'b0;
         chk_count   <= '0;
         err_count   <= '0;
         skip_count  <= '0;
         first_valid <= 1'b0;
         first_sel   <= 4'h0;
         first_a     <= 8'h00;
         first_b     <= 8'h00;
         first_got   <= 8'h00;
         first_exp   <= 8'h00;
         first_cgot  <= 1'b0;
         first_cexp  <= 1'b0;
      end else begin
         s1_valid <= (state_q == RUN) && vec.in_valid && !last;
         s1_a     <= vec.in_a;
         s1_b     <= vec.in_b;
         s1_sel   <= vec.in_sel;
         s1_out   <= vec.in_out;
         s1_carry <= vec.in_carry;
         mismatch <= is_fail;
         if (fire) begin
            acc_q <= acc_q + ONE;
            if (is_skip) begin
               skip_count <= sat_inc(skip_count);
            end else begin
               chk_count <= sat_inc(chk_count);
            end
            if (is_fail) begin
               err_count <= sat_inc(err_count);
               if (!first_valid) begin
                  first_valid <= 1'b1;
                  first_sel   <= s1_sel;
                  first_a     <= s1_a;
                  first_b     <= s1_b;
                  first_got   <= s1_out;
                  first_exp   <= gold;
                  first_cgot  <= s1_carry;
                  first_cexp  <= gold_c;
               end
            end
         end
      end
   end

   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
      pass = done && (err_count == '0);
   end

endmodule
